// File: rtl/friscv_memfy_pkg.sv
// Shared constants and types for the friscv_memfy load/store unit.
package friscv_memfy_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/friscv_memfy_align.sv
// Byte-lane alignment for friscv_memfy: store strobes/data placement and
// load data extraction with sign/zero extension. Purely combinational.
module friscv_memfy_align
  import friscv_memfy_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [XLEN-1:0]   rs2,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] strb,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rd_val
);

  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;

  // A halfword only ever sits on lane 0 or lane 2; off[0] is dropped.
  assign byte_shift = rdata >> {off, 3'b000};
  assign half_shift = rdata >> {off[1], 4'b0000};

  // Select lanes by access size (funct3[1:0]); funct3[2] picks zero extension.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    strb   = 4'b1111;
    wdata  = rs2;
    rd_val = rdata;
    case (funct3[1:0])
      LB[1:0]: begin
        strb   = 4'b0001 << off;
        wdata  = {4{rs2[7:0]}};
        rd_val = funct3[2] ? {24'h0, byte_shift[7:0]}
                           : {{24{byte_shift[7]}}, byte_shift[7:0]};
      end
      LH[1:0]: begin
        strb   = 4'b0011 << {off[1], 1'b0};
        wdata  = {2{rs2[15:0]}};
        rd_val = funct3[2] ? {16'h0, half_shift[15:0]}
                           : {{16{half_shift[15]}}, half_shift[15:0]};
      end
      default: begin
        strb   = 4'b1111;
        wdata  = rs2;
        rd_val = rdata;
      end
    endcase
  end

endmodule

// File: rtl/friscv_memfy.sv
// Load/store unit feeding the memory router: one LOAD/STORE in flight,
// en/ready master request, aligned and extended register write-back.
// Optional build macro FRISCV_MEMFY_MISALIGN_ERR_EN flags misaligned
// halfword/word accesses via memfy_err instead of issuing them.
module friscv_memfy
  import friscv_memfy_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              memfy_valid,
  output logic              memfy_ready,
  input  logic [6:0]        memfy_opcode,
  input  logic [2:0]        memfy_funct3,
  input  logic [XLEN-1:0]   memfy_rs1_val,
  input  logic [XLEN-1:0]   memfy_rs2_val,
  input  logic [11:0]       memfy_imm,
  input  logic [4:0]        memfy_rd,
  output logic              memfy_rd_wr,
  output logic [4:0]        memfy_rd_addr,
  output logic [XLEN-1:0]   memfy_rd_val,
  output logic              memfy_err,
  output logic              mst_en,
  output logic              mst_wr,
  output logic [ADDRW-1:0]  mst_addr,
  output logic [XLEN-1:0]   mst_wdata,
  output logic [XLEN/8-1:0] mst_strb,
  input  logic [XLEN-1:0]   mst_rdata,
  input  logic              mst_ready
);

  typedef struct packed {
    state_t             state;
    logic               en;
    logic               wr;
    logic [ADDRW-1:0]   addr;
    logic [XLEN-1:0]    wdata;
    logic [XLEN/8-1:0]  strb;
    logic               load;
    logic [2:0]         funct3;
    logic [1:0]         off;
    logic [4:0]         rd;
    logic               rd_wr;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_val;
  } regs_t;

  regs_t             r;
  logic [XLEN-1:0]   ea;
  logic [1:0]        off;
  logic              is_load;
  logic              is_store;
  logic              accept;
  logic              misalign;
  logic              start;
  logic [2:0]        al_funct3;
  logic [1:0]        al_off;
  logic [XLEN/8-1:0] al_strb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rd_val;
  logic              unused_ea_hi;

  assign ea           = memfy_rs1_val + {{(XLEN-12){memfy_imm[11]}}, memfy_imm};
  assign off          = ea[1:0];
  assign unused_ea_hi = ^ea[XLEN-1:ADDRW];
  assign is_load      = (memfy_opcode == LOAD);
  assign is_store     = (memfy_opcode == STORE);
  assign memfy_ready  = (r.state == IDLE);
  assign accept       = memfy_valid & memfy_ready;
  assign start        = accept & (is_load | is_store) & ~misalign;

  // Accept and completion never overlap, so one aligner serves both:
  // incoming fields while idle, the registered request while waiting.
  assign al_funct3 = (r.state == REQ) ? r.funct3 : memfy_funct3;
  assign al_off    = (r.state == REQ) ? r.off    : off;

  friscv_memfy_align #(.XLEN(XLEN)) u_align (
    .funct3 (al_funct3),
    .off    (al_off),
    .rs2    (memfy_rs2_val),
    .rdata  (mst_rdata),
    .strb   (al_strb),
    .wdata  (al_wdata),
    .rd_val (al_rd_val)
  );

`ifdef FRISCV_MEMFY_MISALIGN_ERR_EN
  logic err_q;

  assign misalign = ((memfy_funct3[1:0] == LH[1:0]) && off[0]) ||
                    ((memfy_funct3[1:0] == LW[1:0]) && (off != 2'b00));
  assign memfy_err = err_q;

  // One-cycle error pulse for a rejected misaligned LOAD/STORE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  err_q <= 1'b0;
    else if (srst) err_q <= 1'b0;
    else           err_q <= accept & (is_load | is_store) & misalign;
  end
`else
  assign misalign  = 1'b0;
  assign memfy_err = 1'b0;
`endif

  // Request FSM: latch the access on accept, hold it until the target
  // answers, then retire it and write back load data.
  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!aresetn) begin
      r <= '0;
    end else if (srst) begin
      r <= '0;
    end else begin
      r.rd_wr <= 1'b0;
      case (r.state)
        IDLE: begin
          if (start) begin
            r.state  <= REQ;
            r.en     <= 1'b1;
            r.wr     <= is_store;
            r.addr   <= {ea[ADDRW-1:2], 2'b00};
            r.wdata  <= is_store ? al_wdata : '0;
            r.strb   <= al_strb;
            r.load   <= is_load;
            r.funct3 <= memfy_funct3;
            r.off    <= off;
            r.rd     <= memfy_rd;
          end
        end
        REQ: begin
          if (mst_ready) begin
            r.state <= IDLE;
            r.en    <= 1'b0;
            if (r.load && (r.rd != 5'd0)) begin
              r.rd_wr   <= 1'b1;
              r.rd_addr <= r.rd;
              r.rd_val  <= al_rd_val;
            end
          end
        end
        default: r.state <= IDLE;
      endcase
    end
  end

  assign mst_en        = r.en;
  assign mst_wr        = r.wr;
  assign mst_addr      = r.addr;
  assign mst_wdata     = r.wdata;
  assign mst_strb      = r.strb;
  assign memfy_rd_wr   = r.rd_wr;
  assign memfy_rd_addr = r.rd_addr;
  assign memfy_rd_val  = r.rd_val;

endmodule

// File: tb/tb_friscv_memfy.sv
// Self-checking bench for friscv_memfy: directed cases plus randomized
// LOAD/STORE traffic against a byte-lane reference model.
module tb_friscv_memfy;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        srst = 1'b0;
  logic        memfy_valid = 1'b0;
  logic        memfy_ready;
  logic [6:0]  memfy_opcode = '0;
  logic [2:0]  memfy_funct3 = '0;
  logic [31:0] memfy_rs1_val = '0;
  logic [31:0] memfy_rs2_val = '0;
  logic [11:0] memfy_imm = '0;
  logic [4:0]  memfy_rd = '0;
  logic        memfy_rd_wr;
  logic [4:0]  memfy_rd_addr;
  logic [31:0] memfy_rd_val;
  logic        memfy_err;
  logic        mst_en;
  logic        mst_wr;
  logic [15:0] mst_addr;
  logic [31:0] mst_wdata;
  logic [3:0]  mst_strb;
  logic [31:0] mst_rdata = '0;
  logic        mst_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  friscv_memfy #(.ADDRW(16), .XLEN(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .memfy_valid(memfy_valid), .memfy_ready(memfy_ready),
    .memfy_opcode(memfy_opcode), .memfy_funct3(memfy_funct3),
    .memfy_rs1_val(memfy_rs1_val), .memfy_rs2_val(memfy_rs2_val),
    .memfy_imm(memfy_imm), .memfy_rd(memfy_rd),
    .memfy_rd_wr(memfy_rd_wr), .memfy_rd_addr(memfy_rd_addr),
    .memfy_rd_val(memfy_rd_val), .memfy_err(memfy_err),
    .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_strb(mst_strb),
    .mst_rdata(mst_rdata), .mst_ready(mst_ready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: an access of 'size' bytes occupies lanes [base, base+size),
  // base being off rounded down to the access size.
  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic void model(input logic [2:0] f3, input logic [1:0] off,
                                input logic [31:0] rs2, input logic [31:0] rdata,
                                output logic [3:0] strb, output logic [31:0] wdata,
                                output logic [31:0] rdv);
    int size;
    int base;
    size = acc_size(f3);
    base = (int'(off) / size) * size;
    strb = '0;
    rdv  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= base && i < base + size) strb[i] = 1'b1;
      wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
    end
    for (int k = 0; k < size; k++) rdv[8*k +: 8] = rdata[8*(base+k) +: 8];
    if (!f3[2] && size < 4 && rdv[8*size-1])
      for (int b = 8*size; b < 32; b++) rdv[b] = 1'b1;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [1:0] off);
`ifdef FRISCV_MEMFY_MISALIGN_ERR_EN
    return (acc_size(f3) == 2 && off[0]) || (acc_size(f3) == 4 && off != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One complete instruction: issue, check request, stall, complete, check write-back.
  task automatic do_txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [11:0] imm,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [31:0] rdata, input int wait_n);
    logic [31:0] ea;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdv;
    bit          mem_op;
    bit          mis;
    ea     = rs1 + {{20{imm[11]}}, imm};
    mem_op = (op == OP_LOAD) || (op == OP_STORE);
    mis    = mem_op && is_misaligned(f3, ea[1:0]);
    model(f3, ea[1:0], rs2, rdata, e_strb, e_wdata, e_rdv);

    @(negedge aclk);
    check({tag, ".ready_before"}, 32'(memfy_ready), 32'd1);
    memfy_valid = 1'b1; memfy_opcode = op; memfy_funct3 = f3;
    memfy_rs1_val = rs1; memfy_imm = imm; memfy_rs2_val = rs2; memfy_rd = rd;
    mst_ready = 1'b0;
    @(negedge aclk);
    memfy_valid = 1'b0;
    check({tag, ".err"}, 32'(memfy_err), 32'(mis));
    if (!mem_op || mis) begin
      check({tag, ".no_en"}, 32'(mst_en), 32'd0);
      check({tag, ".ready_kept"}, 32'(memfy_ready), 32'd1);
      @(negedge aclk);
      check({tag, ".err_done"}, 32'(memfy_err), 32'd0);
      check({tag, ".no_en2"}, 32'(mst_en), 32'd0);
      return;
    end
    for (int c = 0; c <= wait_n; c++) begin
      check({tag, ".en"}, 32'(mst_en), 32'd1);
      check({tag, ".busy"}, 32'(memfy_ready), 32'd0);
      check({tag, ".wr"}, 32'(mst_wr), 32'(op == OP_STORE));
      check({tag, ".addr"}, 32'(mst_addr), {16'h0, ea[15:2], 2'b00});
      check({tag, ".strb"}, 32'(mst_strb), 32'(e_strb));
      check({tag, ".wdata"}, mst_wdata, (op == OP_STORE) ? e_wdata : 32'h0);
      check({tag, ".rdwr_idle"}, 32'(memfy_rd_wr), 32'd0);
      if (c == wait_n) begin
        mst_ready = 1'b1;
        mst_rdata = rdata;
      end
      @(negedge aclk);
    end
    mst_ready = 1'b0;
    mst_rdata = $urandom;
    check({tag, ".en_drop"}, 32'(mst_en), 32'd0);
    check({tag, ".ready_back"}, 32'(memfy_ready), 32'd1);
    check({tag, ".rd_wr"}, 32'(memfy_rd_wr), 32'((op == OP_LOAD) && (rd != 5'd0)));
    if ((op == OP_LOAD) && (rd != 5'd0)) begin
      check({tag, ".rd_addr"}, 32'(memfy_rd_addr), 32'(rd));
      check({tag, ".rd_val"}, memfy_rd_val, e_rdv);
    end
    @(negedge aclk);
    check({tag, ".rd_wr_pulse"}, 32'(memfy_rd_wr), 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_f3 = '{3'b000, 3'b001, 3'b010};

    // Reset state
    repeat (2) @(negedge aclk);
    check("rst.ready", 32'(memfy_ready), 32'd1);
    check("rst.en", 32'(mst_en), 32'd0);
    check("rst.wr", 32'(mst_wr), 32'd0);
    check("rst.addr", 32'(mst_addr), 32'd0);
    check("rst.wdata", mst_wdata, 32'd0);
    check("rst.strb", 32'(mst_strb), 32'd0);
    check("rst.rd_wr", 32'(memfy_rd_wr), 32'd0);
    check("rst.rd_val", memfy_rd_val, 32'd0);
    check("rst.err", 32'(memfy_err), 32'd0);
    aresetn = 1'b1;

    // Directed cases from the test plan
    do_txn("sw_stall", OP_STORE, 3'b010, 32'h800, 12'd4, 32'hDEADBEEF, 5'd5, 32'h0, 3);
    do_txn("lb", OP_LOAD, 3'b000, 32'h800, 12'd3, 32'h0, 5'd3, 32'h80FF_0000, 0);
    check("lb.abs", memfy_rd_val, 32'hFFFFFF80);
    do_txn("lbu", OP_LOAD, 3'b100, 32'h800, 12'd3, 32'h0, 5'd4, 32'h80FF_0000, 0);
    check("lbu.abs", memfy_rd_val, 32'h00000080);
    do_txn("lh", OP_LOAD, 3'b001, 32'h800, 12'd2, 32'h0, 5'd6, 32'h1234_5678, 1);
    check("lh.abs", memfy_rd_val, 32'h00001234);
    do_txn("sb", OP_STORE, 3'b000, 32'h801, 12'd0, 32'h0000_00AB, 5'd0, 32'h0, 0);
    do_txn("neg_imm", OP_LOAD, 3'b010, 32'h810, 12'hFFC, 32'h0, 5'd7, 32'hCAFE_F00D, 2);
    do_txn("lw_rd0", OP_LOAD, 3'b010, 32'h900, 12'd0, 32'h0, 5'd0, 32'h1111_2222, 0);
    do_txn("unmapped", OP_LOAD, 3'b010, 32'hF000, 12'd0, 32'h0, 5'd9, 32'h0, 0);
    check("unmapped.abs", memfy_rd_val, 32'h0);
    do_txn("lh_off3", OP_LOAD, 3'b001, 32'h803, 12'd0, 32'h0, 5'd10, 32'hA5B6_C7D8, 0);
    do_txn("lw_off2", OP_LOAD, 3'b010, 32'h802, 12'd0, 32'h0, 5'd11, 32'h0102_0304, 0);
    do_txn("drop_op", 7'b0110011, 3'b000, 32'h800, 12'd0, 32'h0, 5'd1, 32'h0, 0);

    // Back-to-back: LW then SW with valid held high throughout
    @(negedge aclk);
    memfy_valid = 1'b1; memfy_opcode = OP_LOAD; memfy_funct3 = 3'b010;
    memfy_rs1_val = 32'hA00; memfy_imm = 12'd0; memfy_rd = 5'd12;
    @(negedge aclk);
    check("b2b.lw_en", 32'(mst_en), 32'd1);
    memfy_opcode = OP_STORE; memfy_rs1_val = 32'hA40; memfy_rs2_val = 32'h5555_AAAA;
    mst_ready = 1'b1; mst_rdata = 32'h7777_8888;
    @(negedge aclk);
    mst_ready = 1'b0;
    check("b2b.lw_rd_wr", 32'(memfy_rd_wr), 32'd1);
    check("b2b.lw_rd_val", memfy_rd_val, 32'h7777_8888);
    check("b2b.ready_m1", 32'(memfy_ready), 32'd1);
    check("b2b.en_m1", 32'(mst_en), 32'd0);
    @(negedge aclk);
    memfy_valid = 1'b0;
    check("b2b.sw_en", 32'(mst_en), 32'd1);
    check("b2b.sw_wr", 32'(mst_wr), 32'd1);
    check("b2b.sw_addr", 32'(mst_addr), 32'hA40);
    check("b2b.rd_wr_once", 32'(memfy_rd_wr), 32'd0);
    mst_ready = 1'b1;
    @(negedge aclk);
    mst_ready = 1'b0;
    check("b2b.sw_done", 32'(mst_en), 32'd0);
    check("b2b.sw_no_rd_wr", 32'(memfy_rd_wr), 32'd0);

    // Async reset in the middle of a request
    @(negedge aclk);
    memfy_valid = 1'b1; memfy_opcode = OP_LOAD; memfy_funct3 = 3'b010;
    memfy_rs1_val = 32'hB00; memfy_imm = 12'd0; memfy_rd = 5'd13;
    @(negedge aclk);
    memfy_valid = 1'b0;
    check("arst.en_before", 32'(mst_en), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("arst.en", 32'(mst_en), 32'd0);
    check("arst.ready", 32'(memfy_ready), 32'd1);
    check("arst.addr", 32'(mst_addr), 32'd0);
    mst_ready = 1'b1; mst_rdata = 32'h1234_0000;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      check("arst.no_rd_wr", 32'(memfy_rd_wr), 32'd0);
    end
    mst_ready = 1'b0;

    // Synchronous reset in the middle of a request
    @(negedge aclk);
    memfy_valid = 1'b1; memfy_opcode = OP_STORE; memfy_funct3 = 3'b010;
    memfy_rs1_val = 32'hC00; memfy_imm = 12'd0;
    @(negedge aclk);
    memfy_valid = 1'b0;
    check("srst.en_before", 32'(mst_en), 32'd1);
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
    check("srst.en", 32'(mst_en), 32'd0);
    check("srst.ready", 32'(memfy_ready), 32'd1);
    check("srst.strb", 32'(mst_strb), 32'd0);

    // Randomized traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      logic        ld;
      logic [2:0]  f3;
      logic [4:0]  rd;
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_txn($sformatf("rnd%0d", t), ld ? OP_LOAD : OP_STORE, f3, $urandom,
             12'($urandom), $urandom, rd, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
